dqs_burst_gen: RTL

- Upstream pattern source for the DQS output path.
- Generates the per-clk_div 4-bit parallel DQS data and tristate nibbles for a DDR3 write strobe: tristate release, write preamble, toggling burst, postamble, re-tristate.
- Feeds the din/tin inputs of oserdes_mem. Bit 0 of each nibble is serialized first.
- Supports seamless back-to-back bursts with no intervening postamble or preamble.

---
 rtl/dqs_burst_gen_if.sv | 25 ++
 rtl/dqs_burst_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dqs_burst_gen_if.sv
// Request/status bundle between a DQS pattern requester and dqs_burst_gen.
// The slave side is the generator; the master side issues bursts and watches the nibbles.
interface dqs_burst_gen_if #(
  parameter int LEN_WIDTH = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 ready;
  logic [3:0]           dqs_din;
  logic [3:0]           dqs_tin;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] burst_cnt;

  modport master (
    output start, len,
    input  ready, dqs_din, dqs_tin, busy, done, burst_cnt
  );

  modport slave (
    input  start, len,
    output ready, dqs_din, dqs_tin, busy, done, burst_cnt
  );
endinterface

// File: rtl/dqs_burst_gen.sv
// DDR3 write-strobe pattern source: emits 4-bit din/tin nibbles for oserdes_mem
// (bit 0 serialized first) covering preamble, toggling burst, postamble and seamless joins.
module dqs_burst_gen #(
  parameter int LEN_WIDTH   = 4,
  parameter int PRE_NIBBLES = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  dqs_burst_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    BURST = 2'd2,
    POST  = 2'd3
  } state_e;

  localparam logic [1:0]           PRE_LOAD = 2'(PRE_NIBBLES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q,   state_d;
  logic [LEN_WIDTH-1:0] nib_cnt_q, nib_cnt_d;
  logic [LEN_WIDTH-1:0] len_q,     len_d;
  logic [1:0]           pre_cnt_q, pre_cnt_d;
  logic [3:0]           din_q,     din_d;
  logic [3:0]           tin_q,     tin_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic                 ready_s;
  logic                 accept_s;

  // Final BURST nibble also accepts, which is what makes back-to-back bursts seamless.
  assign ready_s  = (state_q == IDLE) | ((state_q == BURST) & (nib_cnt_q == LEN_ZERO));
  assign accept_s = bus.start & ready_s;

  // Next-state and counter sequencing.
  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    len_d     = len_q;
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = PRE;
          pre_cnt_d = PRE_LOAD;
          len_d     = bus.len;
        end else begin
          state_d   = IDLE;
        end
      end
      PRE: begin
        if (pre_cnt_q == 2'd0) begin
          state_d   = BURST;
          nib_cnt_d = len_q;
        end else begin
          pre_cnt_d = pre_cnt_q - 2'd1;
        end
      end
      BURST: begin
        if (nib_cnt_q != LEN_ZERO) begin
          nib_cnt_d = nib_cnt_q - LEN_ONE;
        end else if (accept_s) begin
          // Joined burst: the 0101 pattern simply continues, keeping toggle phase.
          nib_cnt_d = bus.len;
        end else begin
          state_d = POST;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      POST: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output nibbles decoded from the next state so they register alongside it.
  always_comb begin
    din_d  = 4'b0000;
    tin_d  = 4'b1111;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE: begin
        din_d = 4'b0000;
        tin_d = 4'b1111;
      end
      PRE: begin
        din_d = 4'b0000;
        tin_d = 4'b0000;
      end
      BURST: begin
        din_d = 4'b0101;
        tin_d = 4'b0000;
      end
      POST: begin
        // Hold low for the first half tCK, then release.
        din_d = 4'b0000;
        tin_d = 4'b1110;
      end
      default: begin
        din_d = 4'b0000;
        tin_d = 4'b1111;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nib_cnt_q <= LEN_ZERO;
      len_q     <= LEN_ZERO;
      pre_cnt_q <= 2'd0;
      din_q     <= 4'b0000;
      tin_q     <= 4'b1111;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      len_q     <= len_d;
      pre_cnt_q <= pre_cnt_d;
      din_q     <= din_d;
      tin_q     <= tin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ready     = ready_s;
  assign bus.dqs_din   = din_q;
  assign bus.dqs_tin   = tin_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.burst_cnt = cnt_q;

endmodule
